sdram_port_arbiter: RTL

- Shares the single SDRAM driver command interface (writer and reader request channels) between the video-input write requester and the video-output read requester.
- Sits in the axi_clk_i domain, between the framebuffer address generators and the SDRAM driver.
- Grants whole aligned bursts, so the driver sees contiguous runs of one type.
- Gives reads priority when the display path is urgent, and bounds starvation of either side.

---
 rtl/sdram_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM driver's writer/reader command channels between the video-in writer
// and the video-out reader, granting whole aligned bursts with urgency and starvation control.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned MAX_WAIT   = 64
) (
    input  logic                  axi_clk_i,
    input  logic                  axi_rst_ni,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  rd_urgent_i,
    output logic                  drv_wr_valid_o,
    input  logic                  drv_wr_ready_i,
    output logic [ADDR_WIDTH-1:0] drv_wr_addr_o,
    output logic [DATA_WIDTH-1:0] drv_wr_data_o,
    output logic                  drv_rd_valid_o,
    input  logic                  drv_rd_ready_i,
    output logic [ADDR_WIDTH-1:0] drv_rd_addr_o,
    output logic [1:0]            grant_o,
    output logic                  starve_o
);
    localparam int unsigned OFFS_W = $clog2(BURST_LEN);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MAX_WAIT);

    // Valid/ready: a beat moves on a channel only in a cycle where both valid and ready are high;
    // the granted requester must hold valid, addr and data stable until that cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WR_BURST = 2'b01,
        RD_BURST = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                starve_q, starve_d;
    logic                last_rd_q, last_rd_d;
    logic                wr_owed_q, wr_owed_d;
    logic                quiet_q, quiet_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wr_wait_q, wr_wait_d;
    logic [WAIT_W-1:0]   rd_wait_q, rd_wait_d;

    logic                in_wr, in_rd;
    logic                cur_valid, cur_ready, beat_acc, burst_end;
    logic                wr_at_lim, rd_at_lim;
    logic [OFFS_W-1:0]   cur_offs;

    assign in_wr     = (state_q == WR_BURST);
    assign in_rd     = (state_q == RD_BURST);
    assign cur_valid = in_wr ? wr_valid_i : rd_valid_i;
    assign cur_ready = in_wr ? drv_wr_ready_i : drv_rd_ready_i;
    assign cur_offs  = in_wr ? wr_addr_i[OFFS_W-1:0] : rd_addr_i[OFFS_W-1:0];
    assign beat_acc  = (in_wr || in_rd) && cur_valid && cur_ready;
    assign wr_at_lim = (wr_wait_q == WAIT_LIM);
    assign rd_at_lim = (rd_wait_q == WAIT_LIM);

    assign drv_wr_valid_o = in_wr && wr_valid_i;
    assign wr_ready_o     = in_wr && drv_wr_ready_i;
    assign drv_wr_addr_o  = in_wr ? wr_addr_i : '0;
    assign drv_wr_data_o  = in_wr ? wr_data_i : '0;
    assign drv_rd_valid_o = in_rd && rd_valid_i;
    assign rd_ready_o     = in_rd && drv_rd_ready_i;
    assign drv_rd_addr_o  = in_rd ? rd_addr_i : '0;
    assign grant_o        = state_q;
    assign starve_o       = starve_q;

    always_comb begin
        state_d   = state_q;
        starve_d  = 1'b0;
        last_rd_d = last_rd_q;
        wr_owed_d = wr_owed_q;
        quiet_d   = quiet_q;
        beat_d    = beat_q;
        burst_end = 1'b0;

        wr_wait_d = (!wr_valid_i || in_wr) ? '0 : (wr_at_lim ? wr_wait_q : wr_wait_q + WAIT_W'(1));
        rd_wait_d = (!rd_valid_i || in_rd) ? '0 : (rd_at_lim ? rd_wait_q : rd_wait_q + WAIT_W'(1));
        if (!wr_valid_i || in_wr) wr_owed_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A starved writer that lost to the reader is owed the very next grant, even over urgency.
                if (wr_owed_q && wr_valid_i) begin
                    state_d  = WR_BURST;
                    starve_d = 1'b1;
                end else if (rd_urgent_i && rd_valid_i) begin
                    state_d = RD_BURST;
                end else if (rd_at_lim && rd_valid_i) begin
                    state_d  = RD_BURST;
                    starve_d = 1'b1;
                end else if (wr_at_lim && wr_valid_i) begin
                    state_d  = WR_BURST;
                    starve_d = 1'b1;
                end else if (wr_valid_i && rd_valid_i) begin
                    state_d = last_rd_q ? WR_BURST : RD_BURST;
                end else if (wr_valid_i) begin
                    state_d = WR_BURST;
                end else if (rd_valid_i) begin
                    state_d = RD_BURST;
                end
                if (state_d == RD_BURST && wr_at_lim && wr_valid_i) wr_owed_d = 1'b1;
            end
            WR_BURST, RD_BURST: begin
                if (beat_acc) begin
                    beat_d    = beat_q + BEAT_W'(1);
                    quiet_d   = 1'b0;
                    burst_end = (beat_q == LAST_BEAT) || (&cur_offs);
                end else if (!cur_valid) begin
                    quiet_d   = 1'b1;
                    burst_end = quiet_q;
                end else begin
                    quiet_d = 1'b0;
                end
                if (burst_end) begin
                    state_d   = IDLE;
                    beat_d    = '0;
                    quiet_d   = 1'b0;
                    last_rd_d = in_rd;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk_i or negedge axi_rst_ni) begin
        if (!axi_rst_ni) begin
            state_q   <= IDLE;
            starve_q  <= 1'b0;
            last_rd_q <= 1'b1;
            wr_owed_q <= 1'b0;
            quiet_q   <= 1'b0;
            beat_q    <= '0;
            wr_wait_q <= '0;
            rd_wait_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            last_rd_q <= last_rd_d;
            wr_owed_q <= wr_owed_d;
            quiet_q   <= quiet_d;
            beat_q    <= beat_d;
            wr_wait_q <= wr_wait_d;
            rd_wait_q <= rd_wait_d;
        end
    end

endmodule
